// File: rtl/key_debounce.sv
// key_debounce: synchronise and debounce active-low push-buttons.
// Emits level, press/release pulses, press toggle, optional long-press.
//
// Ports:
//   clk          system clock, all logic on rising edge
//   reset        synchronous, active-high
//   key_n        raw keys, asynchronous, 0 = pressed
//   key_level    debounced state, 1 = pressed
//   key_press    one-cycle pulse on accepted press
//   key_release  one-cycle pulse on accepted release
//   key_toggle   flips on every accepted press
//   key_long     one-cycle long-press pulse
//
// Build option: define KEY_DEBOUNCE_LONGPRESS_EN to build the per-key
// hold counters; otherwise key_long is tied low.
module key_debounce #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_toggle,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } state_t;

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] s;

  state_t        state_q [NUM_KEYS];
  state_t        state_d [NUM_KEYS];
  logic [CW-1:0] cnt_q   [NUM_KEYS];
  logic [CW-1:0] cnt_d   [NUM_KEYS];

  logic [NUM_KEYS-1:0] press_d;
  logic [NUM_KEYS-1:0] release_d;
  logic [NUM_KEYS-1:0] toggle_d;

  // active-high pressed view of the synchronised key
  assign s = ~sync2;

  always_comb begin
    state_d   = state_q;
    cnt_d     = '{default: '0};
    press_d   = '0;
    release_d = '0;
    toggle_d  = key_toggle;
    for (int k = 0; k < NUM_KEYS; k++) begin
      unique case (state_q[k])
        UP: begin
          if (s[k]) begin
            if (cnt_q[k] == CNT_LAST) begin
              state_d[k]  = DOWN;
              press_d[k]  = 1'b1;
              toggle_d[k] = ~key_toggle[k];
            end else begin
              cnt_d[k] = cnt_q[k] + 1'b1;
            end
          end
        end
        DOWN: begin
          if (!s[k]) begin
            if (cnt_q[k] == CNT_LAST) begin
              state_d[k]   = UP;
              release_d[k] = 1'b1;
            end else begin
              cnt_d[k] = cnt_q[k] + 1'b1;
            end
          end
        end
        default: state_d[k] = UP;
      endcase
    end
  end

  always_comb begin
    key_level = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      key_level[k] = (state_q[k] == DOWN);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= '1;
      sync2       <= '1;
      key_press   <= '0;
      key_release <= '0;
      key_toggle  <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        state_q[k] <= UP;
        cnt_q[k]   <= '0;
      end
    end else begin
      sync1       <= key_n;
      sync2       <= sync1;
      key_press   <= press_d;
      key_release <= release_d;
      key_toggle  <= toggle_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

`ifdef KEY_DEBOUNCE_LONGPRESS_EN
  localparam int LW = $clog2(LONG_CYCLES) + 1;
  localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] HOLD_DONE = LW'(LONG_CYCLES);

  logic [LW-1:0] hold_q [NUM_KEYS];

  // hold_q parks at HOLD_DONE after firing so one press gives one pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      key_long <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        hold_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        key_long[k] <= 1'b0;
        if (state_q[k] == UP) begin
          hold_q[k] <= '0;
        end else if (hold_q[k] == HOLD_LAST) begin
          key_long[k] <= 1'b1;
          hold_q[k]   <= HOLD_DONE;
        end else if (hold_q[k] < HOLD_LAST) begin
          hold_q[k] <= hold_q[k] + 1'b1;
        end
      end
    end
  end
`else
  // always zero; the term only keeps LONG_CYCLES referenced
  assign key_long = {NUM_KEYS{1'b0}} & {NUM_KEYS{LONG_CYCLES > 0}};
`endif

endmodule
